// File: rtl/divisor_nbits.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// WIDTH steps per division, divide-by-zero resolved immediately on acceptance.
module divisor_nbits #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] dvsr;

    logic [WIDTH:0]   shifted_c;
    logic [WIDTH+1:0] trial_c;
    logic [WIDTH:0]   step_rem_c;
    logic             step_bit_c;

    // One restoring step; the extra top bit of trial_c is the borrow/sign.
    always_comb begin
        shifted_c  = {rem[WIDTH-1:0], shreg[WIDTH-1]};
        trial_c    = {rem[WIDTH], shifted_c} - {2'b00, dvsr};
        step_bit_c = ~trial_c[WIDTH+1];
        step_rem_c = step_bit_c ? trial_c[WIDTH:0] : shifted_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            shreg     <= '0;
            dvsr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= dividend;
                        dvsr  <= divisor;
                        cnt   <= '0;
                        rem   <= '0;
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem_c;
                    shreg <= {shreg[WIDTH-2:0], step_bit_c};
                    cnt   <= cnt + 1'b1;
                    // Last step: publish results straight from the step logic.
                    if (cnt == CW'(WIDTH - 1)) begin
                        quotient  <= {shreg[WIDTH-2:0], step_bit_c};
                        remainder <= step_rem_c[WIDTH-1:0];
                        div_zero  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
